// File: rtl/counter_bank_mc.sv
// Multi-channel up/down counter bank with per-channel step, wrap/saturate, sticky flags, threshold compare.
// Latency: count/is_zero/ovf/unf 1 cycle from request; at_thresh 2 cycles from request (1 cycle from count).
// Backpressure: none; every channel accepts a request each cycle while clken is high.
module counter_bank_mc #(
  parameter int                 C_WIDTH      = 16,
  parameter int                 C_NUM_CH     = 4,
  parameter int                 C_STEP_WIDTH = 4,
  parameter int                 C_SATURATE   = 0,
  parameter logic [C_WIDTH-1:0] C_INIT       = '0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clken,
  input  logic [C_NUM_CH-1:0]              load,
  input  logic [C_NUM_CH-1:0]              incr,
  input  logic [C_NUM_CH-1:0]              decr,
  input  logic [C_NUM_CH*C_WIDTH-1:0]      load_value,
  input  logic [C_NUM_CH*C_STEP_WIDTH-1:0] step,
  input  logic [C_WIDTH-1:0]               threshold,
  input  logic [C_NUM_CH-1:0]              clr_flags,
  output logic [C_NUM_CH*C_WIDTH-1:0]      count,
  output logic [C_NUM_CH-1:0]              is_zero,
  output logic [C_NUM_CH-1:0]              at_thresh,
  output logic [C_NUM_CH-1:0]              ovf,
  output logic [C_NUM_CH-1:0]              unf
);

  localparam logic [C_WIDTH-1:0] ALL_ONES = '1;

  for (genvar i = 0; i < C_NUM_CH; i++) begin : g_ch
    logic [C_WIDTH-1:0] cnt_q;
    logic [C_WIDTH-1:0] cnt_nxt;
    logic [C_WIDTH-1:0] step_ext;
    logic [C_WIDTH:0]   sum;
    logic [C_WIDTH-1:0] diff;
    logic               ovf_evt;
    logic               unf_evt;
    logic               zero_q;
    logic               thr_q;
    logic               ovf_q;
    logic               unf_q;

    // Step is zero-extended; the extra sum bit exposes the carry-out as the overflow event.
    assign step_ext = C_WIDTH'(step[i*C_STEP_WIDTH +: C_STEP_WIDTH]);
    assign sum      = {1'b0, cnt_q} + {1'b0, step_ext};
    assign diff     = cnt_q - step_ext;

    // Next-state selection: load beats incr-only beats decr-only; incr+decr together holds.
    always_comb begin
      cnt_nxt = cnt_q;
      ovf_evt = 1'b0;
      unf_evt = 1'b0;
      if (load[i]) begin
        cnt_nxt = load_value[i*C_WIDTH +: C_WIDTH];
      end else if (incr[i] && !decr[i]) begin
        ovf_evt = sum[C_WIDTH];
        cnt_nxt = (ovf_evt && C_SATURATE != 0) ? ALL_ONES : sum[C_WIDTH-1:0];
      end else if (!incr[i] && decr[i]) begin
        unf_evt = (step_ext > cnt_q);
        cnt_nxt = (unf_evt && C_SATURATE != 0) ? '0 : diff;
      end
    end

    // Count and zero flag advance only under clken; zero flag is derived from the next count
    // so it is aligned with the registered count.
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q  <= C_INIT;
        zero_q <= (C_INIT == '0);
      end else if (clken) begin
        cnt_q  <= cnt_nxt;
        zero_q <= (cnt_nxt == '0);
      end
    end

    // Threshold compare on the registered count, refreshed every cycle independent of clken.
    always_ff @(posedge clk) begin
      if (rst) thr_q <= 1'b0;
      else     thr_q <= (cnt_q >= threshold);
    end

    // Sticky flags: a new event under clken sets; clr_flags clears; set wins on collision.
    always_ff @(posedge clk) begin
      if (rst) begin
        ovf_q <= 1'b0;
        unf_q <= 1'b0;
      end else begin
        ovf_q <= (clken & ovf_evt) | (ovf_q & ~clr_flags[i]);
        unf_q <= (clken & unf_evt) | (unf_q & ~clr_flags[i]);
      end
    end

    assign count[i*C_WIDTH +: C_WIDTH] = cnt_q;
    assign is_zero[i]                  = zero_q;
    assign at_thresh[i]                = thr_q;
    assign ovf[i]                      = ovf_q;
    assign unf[i]                      = unf_q;
  end

endmodule

// File: tb/tb_counter_bank_mc.sv
// Directed test of counter_bank_mc: one wrapping and one saturating instance share all inputs.
// Expected values are hand-computed constants per step.
// Inputs change 1 time unit after the rising edge; outputs are checked at that same point.
module tb_counter_bank_mc;

  localparam int W  = 8;
  localparam int NC = 4;
  localparam int SW = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              clken;
  logic [NC-1:0]     load, incr, decr, clr_flags;
  logic [NC*W-1:0]   load_value;
  logic [NC*SW-1:0]  step;
  logic [W-1:0]      threshold;

  logic [NC*W-1:0]   cnt_w, cnt_s;
  logic [NC-1:0]     zero_w, zero_s, thr_w, thr_s, ovf_w, ovf_s, unf_w, unf_s;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  counter_bank_mc #(.C_WIDTH(W), .C_NUM_CH(NC), .C_STEP_WIDTH(SW), .C_SATURATE(0), .C_INIT(8'd5)) u_wrap (
    .clk(clk), .rst(rst), .clken(clken), .load(load), .incr(incr), .decr(decr),
    .load_value(load_value), .step(step), .threshold(threshold), .clr_flags(clr_flags),
    .count(cnt_w), .is_zero(zero_w), .at_thresh(thr_w), .ovf(ovf_w), .unf(unf_w));

  counter_bank_mc #(.C_WIDTH(W), .C_NUM_CH(NC), .C_STEP_WIDTH(SW), .C_SATURATE(1), .C_INIT(8'd5)) u_sat (
    .clk(clk), .rst(rst), .clken(clken), .load(load), .incr(incr), .decr(decr),
    .load_value(load_value), .step(step), .threshold(threshold), .clr_flags(clr_flags),
    .count(cnt_s), .is_zero(zero_s), .at_thresh(thr_s), .ovf(ovf_s), .unf(unf_s));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; clken = 1'b1;
    load = '0; incr = 4'hF; decr = '0; clr_flags = '0;
    load_value = '0; step = 16'h1111; threshold = 8'd200;
    #1;

    // Reset held two cycles with incr active
    tick(); tick();
    check("rst_count_wrap", cnt_w, 32'h05050505);
    check("rst_count_sat",  cnt_s, 32'h05050505);
    check("rst_is_zero",    zero_w, 4'h0);
    check("rst_at_thresh",  thr_w, 4'h0);
    check("rst_ovf",        ovf_w, 4'h0);
    check("rst_unf",        unf_w, 4'h0);

    // First increment after release
    rst = 1'b0;
    tick();
    check("post_rst_incr", cnt_w, 32'h06060606);
    incr = '0;

    // Wrap: ch0 load 250, +10 -> 4 with ovf, then -5 -> 255 with unf
    load = 4'h1; load_value[0 +: W] = 8'd250;
    tick();
    load = '0; incr = 4'h1; step[0 +: SW] = 4'd10;
    tick();
    check("wrap_incr_ch0",  cnt_w[0 +: W], 8'd4);
    check("wrap_ovf",       ovf_w, 4'h1);
    check("wrap_other_ch",  cnt_w[W +: 3*W], 24'h060606);
    incr = '0; decr = 4'h1; step[0 +: SW] = 4'd5;
    tick();
    check("wrap_decr_ch0",  cnt_w[0 +: W], 8'd255);
    check("wrap_unf",       unf_w, 4'h1);
    decr = '0;

    // Saturate: ch1 load 3, -7 -> 0 with unf; load 254, +3 -> 255 with ovf
    load = 4'h2; load_value[W +: W] = 8'd3;
    tick();
    load = '0; decr = 4'h2; step[SW +: SW] = 4'd7;
    tick();
    check("sat_decr_ch1",   cnt_s[W +: W], 8'd0);
    check("sat_is_zero1",   zero_s[1], 1'b1);
    check("sat_unf1",       unf_s[1], 1'b1);
    decr = '0; load = 4'h2; load_value[W +: W] = 8'd254;
    tick();
    load = '0; incr = 4'h2; step[SW +: SW] = 4'd3;
    tick();
    check("sat_incr_ch1",   cnt_s[W +: W], 8'd255);
    check("sat_ovf1",       ovf_s[1], 1'b1);
    incr = '0;

    // Priority on wrap ch2 (currently 6)
    load = 4'h4; incr = 4'h4; load_value[2*W +: W] = 8'd20; step[2*SW +: SW] = 4'd1;
    tick();
    check("load_beats_incr", cnt_w[2*W +: W], 8'd20);
    load = '0; incr = 4'h4; decr = 4'h4;
    tick();
    check("incr_decr_hold",  cnt_w[2*W +: W], 8'd20);
    decr = '0; clken = 1'b0;
    tick();
    check("clken_off_hold",  cnt_w[2*W +: W], 8'd20);
    clken = 1'b1; incr = '0;

    // Clear coincident with a new overflow on wrap ch0: set wins
    load = 4'h1; load_value[0 +: W] = 8'd255;
    tick();
    load = '0; incr = 4'h1; step[0 +: SW] = 4'd1; clr_flags = 4'h1;
    tick();
    check("clr_vs_set_ovf", ovf_w[0], 1'b1);
    check("clr_vs_set_cnt", cnt_w[0 +: W], 8'd0);
    check("clr_unf0",       unf_w[0], 1'b0);
    incr = '0;
    tick();
    check("clr_alone_ovf",  ovf_w[0], 1'b0);
    clr_flags = '0;

    // Threshold latency on wrap ch2: 8 -> 9 -> 10
    threshold = 8'd10;
    load = 4'h4; load_value[2*W +: W] = 8'd8;
    tick();
    load = '0; incr = 4'h4;
    tick();
    check("thr_at_9",       thr_w[2], 1'b0);
    tick();
    incr = '0;
    check("thr_cnt_10",     cnt_w[2*W +: W], 8'd10);
    check("thr_edge_plus1", thr_w[2], 1'b0);
    tick();
    check("thr_edge_plus2", thr_w[2], 1'b1);

    // Threshold zero with clken low
    threshold = 8'd0; clken = 1'b0;
    tick();
    check("thr_zero_all",   thr_w, 4'hF);
    clken = 1'b1;

    // Reset during continuous counting
    incr = 4'hF; step = 16'h1111;
    for (int k = 0; k < 20; k++) tick();
    rst = 1'b1;
    tick();
    check("midrst_count_w", cnt_w, 32'h05050505);
    check("midrst_count_s", cnt_s, 32'h05050505);
    check("midrst_ovf_s",   ovf_s, 4'h0);
    check("midrst_unf_w",   unf_w, 4'h0);
    check("midrst_thr",     thr_w, 4'h0);
    rst = 1'b0;
    tick();
    check("resume_count",   cnt_w, 32'h06060606);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_bank_mc.md
Name: counter_bank_mc

Overview:
- Multi-channel, parametrised up/down counter bank for kernel-side bookkeeping: outstanding-transaction tracking, burst/beat counting, and credit counting.
- Successor to the single-channel load/incr/decr counter. Adds:
  - independent channels
  - per-channel variable step
  - wrap or saturate mode
  - sticky overflow/underflow flags
  - threshold compare
- Sits between the AXI master control logic and the kernel control FSM.

Parameters:
- C_WIDTH, 16, counter width per channel (2..32).
- C_NUM_CH, 4, number of independent channels (1..16).
- C_STEP_WIDTH, 4, width of per-channel step value (1..C_WIDTH).
- C_SATURATE, 0, 0 = modulo-2^C_WIDTH wrap, 1 = clamp at 0 / all-ones.
- C_INIT, 0, reset/initial value of every channel (C_WIDTH bits).

Ports:
- clk  in  1  clock.
- rst  in  1  reset rst, synchronous, active-high; clock clk.
- clken  in  1  global count enable; gates load/incr/decr for all channels.
- load  in  C_NUM_CH  per-channel load strobe.
- incr  in  C_NUM_CH  per-channel increment request.
- decr  in  C_NUM_CH  per-channel decrement request.
- load_value  in  C_NUM_CH*C_WIDTH  per-channel load data; channel i occupies bits [i*C_WIDTH +: C_WIDTH].
- step  in  C_NUM_CH*C_STEP_WIDTH  per-channel step magnitude, zero-extended; channel i occupies bits [i*C_STEP_WIDTH +: C_STEP_WIDTH].
- threshold  in  C_WIDTH  shared compare threshold (unsigned).
- clr_flags  in  C_NUM_CH  per-channel sticky-flag clear.
- count  out  C_NUM_CH*C_WIDTH  current count per channel, same packing as load_value.
- is_zero  out  C_NUM_CH  count == 0, registered.
- at_thresh  out  C_NUM_CH  count >= threshold, registered.
- ovf  out  C_NUM_CH  sticky overflow flag.
- unf  out  C_NUM_CH  sticky underflow flag.

Behaviour:
- Reset values (rst high at a clk edge):
  - count = C_INIT.
  - is_zero = (C_INIT == 0).
  - at_thresh = 0, ovf = 0, unf = 0.
  - rst overrides every other input, including mid-count.
- Per-channel update priority when clken = 1: load > (incr & ~decr) > (~incr & decr) > hold.
  - incr & decr both high = hold. No flag effect.
  - clken = 0: count and is_zero hold. load/incr/decr are ignored.
- load: count <= load_value[i]. is_zero <= (load_value[i] == 0). No ovf/unf effect.
- Increment: sum = count + step, computed in C_WIDTH+1 bits.
  - If sum > all-ones, the event is an overflow.
  - C_SATURATE = 0: count <= sum[C_WIDTH-1:0] (wrap).
  - C_SATURATE = 1: count <= all-ones.
- Decrement: if step > count, the event is an underflow.
  - C_SATURATE = 0: count <= (count - step) mod 2^C_WIDTH.
  - C_SATURATE = 1: count <= 0.
- step = 0: count unchanged. No flag effect. Counts as a no-op.
- Latency: count, is_zero, ovf and unf update on the clk edge where the request is sampled (1 cycle).
  - is_zero is always equal to (count == 0) in the same cycle. It is computed from the next-state value, not from a compare on the registered count.
- at_thresh: registered (count_r >= threshold) with a further cycle of latency (2 cycles from the request).
  - Updated every cycle regardless of clken. 0 during reset.
- Sticky flags:
  - Set on an overflow/underflow event while clken = 1.
  - Cleared by clr_flags[i] regardless of clken.
  - Set and clear in the same cycle: set wins (flag = 1).
  - Flags are cleared only by clr_flags or rst; never self-cleared.
- Channels are fully independent. Activity on channel i never affects channel j.
- No combinational path from inputs to outputs.

Test Plan:
- Reset/defaults: C_INIT = 5, C_WIDTH = 8, C_NUM_CH = 4. Hold rst for 2 cycles with incr = 4'hF. Required: count = 5 on all channels, is_zero = 0, at_thresh/ovf/unf = 0. Release rst; one incr cycle with step = 1 gives count = 6.
- Wrap mode (C_SATURATE = 0, C_WIDTH = 8): ch0 load 250, then incr step = 10. Required: count = 4, ovf[0] = 1, other channels unchanged. Then decr step = 5: count = 255, unf[0] = 1.
- Saturate mode (C_SATURATE = 1): ch1 load 3, then decr step = 7. Required: count = 0, is_zero[1] = 1 in the same cycle, unf[1] = 1. Then load 254, incr step = 3: count = 255, ovf[1] = 1.
- Priority/simultaneity:
  - load + incr in the same cycle: load_value wins.
  - incr + decr together: hold.
  - clken = 0 with incr: hold.
  - clr_flags coincident with a new overflow: ovf stays 1. clr_flags alone in a later cycle: ovf = 0.
- Threshold: threshold = 10. Incr ch2 by step 1 from 8. Required: at_thresh[2] rises exactly 2 cycles after the request that makes count = 10. Lower threshold to 0: all at_thresh = 1 one cycle later, even with clken = 0.
- Reset mid-operation: continuous incr on all channels for 20 cycles, assert rst for 1 cycle. Required: count = C_INIT on the next edge, sticky flags cleared, counting resumes the cycle after rst falls.
